// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped 2-bit counter table plus tagged BTB,
// with ID-stage training and mispredict/redirect. Optional stats via BP_STATS_EN.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IF_pc,
    output logic        IF_predict_taken,
    output logic [31:0] IF_predict_target,
    input  logic        ID_branch,
    input  logic [31:0] ID_pc,
    input  logic        ID_CompareResult,
    input  logic [31:0] ID_target,
    input  logic        ID_pred_taken,
    input  logic [31:0] ID_pred_target,
    output logic        ID_mispredict,
    output logic [31:0] ID_redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic                tbl_valid  [ENTRIES];
    logic [TAG_BITS-1:0] tbl_tag    [ENTRIES];
    logic [1:0]          tbl_cnt    [ENTRIES];
    logic [31:0]         tbl_target [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic                if_hit;
    logic [IDX_BITS-1:0] id_idx;
    logic [TAG_BITS-1:0] id_tag;
    logic                id_hit;
    logic                target_wrong;
    logic [2+IDX_BITS+TAG_BITS-1:0] unused_if_pc;

    assign if_idx = IF_pc[IDX_BITS+1:2];
    assign if_tag = IF_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign id_idx = ID_pc[IDX_BITS+1:2];
    assign id_tag = ID_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign unused_if_pc = {IF_pc[31:IDX_BITS+TAG_BITS+2], IF_pc[1:0]};

    // Lookup reads the registered table directly, so IF sees pre-update contents.
    assign if_hit            = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
    assign IF_predict_taken  = if_hit && tbl_cnt[if_idx][1];
    assign IF_predict_target = IF_predict_taken ? tbl_target[if_idx] : 32'd0;

    assign id_hit        = tbl_valid[id_idx] && (tbl_tag[id_idx] == id_tag);
    assign target_wrong  = (ID_target != ID_pred_target);
    assign ID_mispredict = ID_branch &&
                           ((ID_CompareResult != ID_pred_taken) ||
                            (ID_CompareResult && ID_pred_taken && target_wrong));
    assign ID_redirect_pc = ID_CompareResult ? ID_target : ID_pc + 32'd4;

    // Training: counters saturate; a taken miss allocates (and evicts any alias) as weak-taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_cnt[i]    <= 2'b01;
                tbl_target[i] <= 32'd0;
            end
        end else if (ID_branch) begin
            if (id_hit) begin
                if (ID_CompareResult) begin
                    tbl_cnt[id_idx]    <= sat_inc(tbl_cnt[id_idx]);
                    tbl_target[id_idx] <= ID_target;
                end else begin
                    tbl_cnt[id_idx] <= sat_dec(tbl_cnt[id_idx]);
                end
            end else if (ID_CompareResult) begin
                tbl_valid[id_idx]  <= 1'b1;
                tbl_tag[id_idx]    <= id_tag;
                tbl_cnt[id_idx]    <= 2'b10;
                tbl_target[id_idx] <= ID_target;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (ID_branch)     stat_branches    <= stat_branches + 32'd1;
            if (ID_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor against an arithmetic reference model.
module tb_branch_predictor;

    localparam int IDX_BITS = 6;
    localparam int TAG_BITS = 8;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic        clk;
    logic        reset_n;
    logic [31:0] IF_pc;
    logic        IF_predict_taken;
    logic [31:0] IF_predict_target;
    logic        ID_branch;
    logic [31:0] ID_pc;
    logic        ID_CompareResult;
    logic [31:0] ID_target;
    logic        ID_pred_taken;
    logic [31:0] ID_pred_target;
    logic        ID_mispredict;
    logic [31:0] ID_redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .IF_pc             (IF_pc),
        .IF_predict_taken  (IF_predict_taken),
        .IF_predict_target (IF_predict_target),
        .ID_branch         (ID_branch),
        .ID_pc             (ID_pc),
        .ID_CompareResult  (ID_CompareResult),
        .ID_target         (ID_target),
        .ID_pred_taken     (ID_pred_taken),
        .ID_pred_target    (ID_pred_target),
        .ID_mispredict     (ID_mispredict),
        .ID_redirect_pc    (ID_redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one record per index, counter kept as a plain integer 0..3.
    bit          m_v   [ENTRIES];
    int unsigned m_tag [ENTRIES];
    int          m_cnt [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];
    int unsigned s_br, s_mp;

    logic        obs_tk, obs_mp;
    logic [31:0] obs_tgt, obs_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> (IDX_BITS + 2)) % (32'd1 << TAG_BITS);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_cnt[i] = 1; m_tgt[i] = 32'd0;
        end
        s_br = 0; s_mp = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
        tk  = m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
        tgt = tk ? m_tgt[idx_of(pc)] : 32'd0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic res, input logic [31:0] tgt);
        int i;
        i = idx_of(pc);
        if (m_hit(pc)) begin
            if (res) begin
                m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                m_tgt[i] = tgt;
            end else begin
                m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
            end
        end else if (res) begin
            m_v[i] = 1; m_tag[i] = tag_of(pc); m_cnt[i] = 2; m_tgt[i] = tgt;
        end
    endtask

    task automatic step(input logic [31:0] ifpc, input logic br, input logic [31:0] idpc,
                        input logic res, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
        logic        etk, emp;
        logic [31:0] etgt;
        @(negedge clk);
        IF_pc = ifpc; ID_branch = br; ID_pc = idpc; ID_CompareResult = res;
        ID_target = tgt; ID_pred_taken = ptk; ID_pred_target = ptgt;
        #1;
        model_lookup(ifpc, etk, etgt);
        emp = br && ((res != ptk) || (res && ptk && (tgt != ptgt)));
        obs_tk = IF_predict_taken; obs_tgt = IF_predict_target;
        obs_mp = ID_mispredict;    obs_rd = ID_redirect_pc;
        chk("if_taken",  {31'd0, obs_tk}, {31'd0, etk});
        chk("if_target", obs_tgt, etgt);
        chk("mispredict", {31'd0, obs_mp}, {31'd0, emp});
        if (br) chk("redirect", obs_rd, res ? tgt : idpc + 32'd4);
        @(posedge clk);
        if (br) begin
            model_update(idpc, res, tgt);
            s_br++;
            if (emp) s_mp++;
        end
`ifdef BP_STATS_EN
        #1;
        chk("stat_br", stat_branches, s_br);
        chk("stat_mp", stat_mispredicts, s_mp);
`endif
    endtask

    // Reset asserted while an allocating update is presented; that update must be lost.
    task automatic do_reset(input logic [31:0] pc);
        @(negedge clk);
        ID_branch = 1'b1; ID_pc = pc; ID_CompareResult = 1'b1; ID_target = 32'h80;
        ID_pred_taken = 1'b0; ID_pred_target = 32'd0; IF_pc = pc;
        #2 reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_taken",  {31'd0, IF_predict_taken}, 32'd0);
        chk("rst_target", IF_predict_target, 32'd0);
`ifdef BP_STATS_EN
        chk("rst_stat_br", stat_branches, 32'd0);
        chk("rst_stat_mp", stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        ID_branch = 1'b0;
        reset_n = 1'b1;
    endtask

    logic [31:0] pool [8];

    initial begin
        reset_n = 1'b0; IF_pc = 32'd0; ID_branch = 1'b0; ID_pc = 32'd0;
        ID_CompareResult = 1'b0; ID_target = 32'd0; ID_pred_taken = 1'b0; ID_pred_target = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Test 1: cold lookup misses
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t1_taken", {31'd0, obs_tk}, 32'd0);
        chk("t1_target", obs_tgt, 32'd0);

        // Tests 2/3: allocate, then train up and down
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("t2_mp", {31'd0, obs_mp}, 32'd1);
        chk("t2_rd", obs_rd, 32'h80);
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("t2_taken", {31'd0, obs_tk}, 32'd1);
        chk("t2_target", obs_tgt, 32'h80);
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        step(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        chk("t3_after_nt1", {31'd0, obs_tk}, 32'd1);
        chk("t3_nt_rd", obs_rd, 32'h104);
        step(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        chk("t3_before_nt2", {31'd0, obs_tk}, 32'd1);
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t3_after_nt2", {31'd0, obs_tk}, 32'd0);

        // Test 4: right direction, wrong target
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        chk("t4_mp", {31'd0, obs_mp}, 32'd1);
        chk("t4_rd", obs_rd, 32'h90);
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t4_newtgt", obs_tgt, 32'h90);

        // Test 5: alias retags the entry
        step(32'h100, 1'b1, 32'h100 + (32'd4 << IDX_BITS), 1'b1, 32'hA0, 1'b0, 32'h0);
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t5_old_miss", {31'd0, obs_tk}, 32'd0);
        step(32'h100 + (32'd4 << IDX_BITS), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t5_new_hit", obs_tgt, 32'hA0);
        step(32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h80, 1'b0, 32'h0);
        chk("wrap_rd", obs_rd, 32'h0);

        // Test 6: reset mid-update, then stats 3/1
        do_reset(32'h100);
        step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6_discard", {31'd0, obs_tk}, 32'd0);
        step(32'h0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        step(32'h0, 1'b1, 32'h300, 1'b1, 32'h40, 1'b0, 32'h0);
        step(32'h0, 1'b1, 32'h300, 1'b1, 32'h40, 1'b1, 32'h40);
`ifdef BP_STATS_EN
        chk("t6_br", stat_branches, 32'd3);
        chk("t6_mp", stat_mispredicts, 32'd1);
`endif
        do_reset(32'h300);

        // Randomized traffic over a small PC pool with aliases and the wrap address
        pool[0] = 32'h100;      pool[1] = 32'h200;      pool[2] = 32'h104;  pool[3] = 32'h3F00;
        pool[4] = 32'hFFFF_FFFC; pool[5] = 32'h1234_5678; pool[6] = 32'h10100; pool[7] = 32'h40;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ifpc, idpc, tgt, ptgt;
            logic        br, res, ptk;
            ifpc = pool[$urandom_range(7)];
            idpc = pool[$urandom_range(7)];
            br   = ($urandom_range(3) != 0);
            res  = $urandom_range(1) != 0;
            case ($urandom_range(2))
                0: tgt = 32'h80;
                1: tgt = 32'h90;
                default: tgt = $urandom & 32'hFFFF_FFFC;
            endcase
            if ($urandom_range(3) != 0) model_lookup(idpc, ptk, ptgt);
            else begin
                ptk  = $urandom_range(1) != 0;
                ptgt = ($urandom_range(1) != 0) ? 32'h80 : 32'h90;
            end
            step(ifpc, br, idpc, res, tgt, ptk, ptgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
